count_sequencer: RTL and testbench

Controller that sequences the loadable 4-bit decade counter datapath: load, start, stop, pause and terminal-count stop.
- Converts three raw push-button levels into single-cycle events.
- Divides the 50 MHz board clock into count ticks.
- Issues one-cycle load and step strobes to the counter, and watches its Q to detect the terminal count and decade rollovers.
- Sits between the board KEY/SW inputs and the counter, ahead of the BCD/7-segment display path.

---
 rtl/count_seq_pkg.sv | 17 +
 rtl/btn_edge_sync.sv | 29 ++
 rtl/count_sequencer.sv | 144 ++++++++++++++
 tb/tb_count_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared state encoding and default timing constants for the decade-counter
// sequencer.
package count_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DIV_W_DEF   = 26;
  localparam int DIV_MAX_DEF = 49_999_999;
  localparam int CNT_MAX_DEF = 9;

endpackage

// File: rtl/btn_edge_sync.sv
// Brings a raw push-button level into the clk domain and emits a single-cycle
// event on each rising edge of the synchronized level.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic evt_out
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // History is cleared by reset, so a button held through reset still fires once.
  assign evt_out = sync2_q & ~hist_q;

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for the loadable decade counter: turns button events into load and
// step strobes, paces stepping with a prescaler and stops at the terminal count.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_MAX = DIV_MAX_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       load_btn,
  input  logic [3:0] load_val,
  input  logic [3:0] term_val,
  input  logic [3:0] cnt_q,
  output logic [3:0] cnt_d,
  output logic       cnt_load,
  output logic       cnt_step,
  output logic [3:0] wraps,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(DIV_MAX);
  localparam logic [3:0]       CNT_MAX_C = 4'(CNT_MAX);

  logic start_evt;
  logic stop_evt;
  logic load_evt;

  state_e           state_q,  state_d;
  logic [DIV_W-1:0] presc_q,  presc_d;
  logic [3:0]       wraps_q,  wraps_d;
  logic [3:0]       cnt_d_q,  cnt_d_d;
  logic             load_q,   load_d;
  logic             step_q,   step_d;

  logic tick;
  logic term_hit;

  btn_edge_sync u_start (.clk(clk), .rst(rst), .btn_in(start_btn), .evt_out(start_evt));
  btn_edge_sync u_stop  (.clk(clk), .rst(rst), .btn_in(stop_btn),  .evt_out(stop_evt));
  btn_edge_sync u_load  (.clk(clk), .rst(rst), .btn_in(load_btn),  .evt_out(load_evt));

  assign tick     = (presc_q == DIV_MAX_C);
  // Out-of-range terminal values can never be reached by a decade counter.
  assign term_hit = (term_val <= CNT_MAX_C) && (cnt_q == term_val);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    wraps_d = wraps_q;
    cnt_d_d = cnt_d_q;
    load_d  = 1'b0;
    step_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_evt) begin
          state_d = LOAD;
        end else if (start_evt) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      RUN: begin
        if (load_evt) begin
          state_d = LOAD;
        end else if (stop_evt) begin
          state_d = PAUSE;
        end else begin
          presc_d = tick ? '0 : presc_q + DIV_W'(1);
          if (tick) begin
            if (term_hit) begin
              state_d = DONE;
            end else begin
              step_d = 1'b1;
              if (cnt_q == CNT_MAX_C) begin
                wraps_d = wraps_q + 4'd1;
              end
            end
          end
        end
      end
      PAUSE: begin
        if (load_evt) begin
          state_d = LOAD;
        end else if (stop_evt) begin
          state_d = IDLE;
        end else if (start_evt) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (load_evt) begin
          state_d = LOAD;
        end else if (stop_evt) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // LOAD is only ever entered from another state, so this marks LOAD entry.
    if (state_d == LOAD) begin
      load_d  = 1'b1;
      cnt_d_d = load_val;
      wraps_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      wraps_q <= '0;
      cnt_d_q <= '0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      wraps_q <= wraps_d;
      cnt_d_q <= cnt_d_d;
      load_q  <= load_d;
      step_q  <= step_d;
    end
  end

  assign cnt_d    = cnt_d_q;
  assign cnt_load = load_q;
  assign cnt_step = step_q;
  assign wraps    = wraps_q;
  assign done     = (state_q == DONE);
  assign state    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a fast prescaler and a behavioural
// decade counter closing the loop on cnt_q.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       stop_btn  = 1'b0;
  logic       load_btn  = 1'b0;
  logic [3:0] load_val  = 4'd0;
  logic [3:0] term_val  = 4'd0;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       cnt_load;
  logic       cnt_step;
  logic [3:0] wraps;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mask;
  logic [2:0]  st_mid;
  int          nsteps;

  count_sequencer #(
    .DIV_W  (26),
    .DIV_MAX(3),
    .CNT_MAX(9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .load_btn (load_btn),
    .load_val (load_val),
    .term_val (term_val),
    .cnt_q    (cnt_q),
    .cnt_d    (cnt_d),
    .cnt_load (cnt_load),
    .cnt_step (cnt_step),
    .wraps    (wraps),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Decade counter datapath with one cycle of latency.
  always @(posedge clk) begin
    if (rst)           cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_step) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
  end

  task automatic step_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: bit0 start, bit1 stop, bit2 load. Returns on the negedge after the FSM acted.
  task automatic press(input logic [2:0] which);
    start_btn = which[0];
    stop_btn  = which[1];
    load_btn  = which[2];
    step_n(3);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    load_btn  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every button pressed.
    load_val  = 4'd5;
    start_btn = 1'b1;
    stop_btn  = 1'b1;
    load_btn  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs", 32'({cnt_d, cnt_load, cnt_step, wraps, done, state}), 32'd0);
    end
    rst = 1'b0;
    step_n(2);
    chk("rel_no_early_evt", 32'(state), 32'd0);
    step_n(1);
    chk("rel_load_state", 32'(state), 32'd1);
    chk("rel_load_strobe", 32'({cnt_load, cnt_step}), 32'b10);
    chk("rel_cnt_d", 32'(cnt_d), 32'd5);
    step_n(1);
    chk("rel_back_idle", 32'({state, cnt_load}), 32'd0);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    load_btn  = 1'b0;
    step_n(4);
    chk("rel_single_evt", 32'({state, cnt_load, cnt_step}), 32'd0);

    // Count 2 -> 6 then stop at terminal count.
    load_val = 4'd2;
    term_val = 4'd6;
    press(3'b100);
    chk("t2_load", 32'({state, cnt_load, cnt_d}), {24'd0, 3'd1, 1'b1, 4'd2});
    step_n(1);
    chk("t2_cnt_loaded", 32'(cnt_q), 32'd2);
    press(3'b001);
    chk("t2_run", 32'(state), 32'd2);
    mask = '0;
    st_mid = '0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      mask = mask | (32'(cnt_step) << i);
      if (i == 19) st_mid = state;
    end
    chk("t2_step_pattern", mask, 32'h0001_1110);
    chk("t2_still_run", 32'(st_mid), 32'd2);
    chk("t2_done", 32'({state, done}), {28'd0, 3'd4, 1'b1});
    chk("t2_cnt_final", 32'(cnt_q), 32'd6);
    chk("t2_wraps", 32'(wraps), 32'd0);
    press(3'b001);
    chk("t2_start_ignored", 32'(state), 32'd4);

    // Count 7 -> 3 through a decade rollover, loading straight from DONE.
    load_val = 4'd7;
    term_val = 4'd3;
    press(3'b100);
    chk("t3_load_from_done", 32'(state), 32'd1);
    step_n(1);
    chk("t3_cnt_loaded", 32'(cnt_q), 32'd7);
    press(3'b001);
    chk("t3_run", 32'(state), 32'd2);
    mask = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      mask = mask | (32'(cnt_step) << i);
      if (i == 27) st_mid = state;
    end
    chk("t3_step_pattern", mask, 32'h0111_1110);
    chk("t3_still_run", 32'(st_mid), 32'd2);
    chk("t3_done", 32'({state, done}), {28'd0, 3'd4, 1'b1});
    chk("t3_wraps", 32'(wraps), 32'd1);
    chk("t3_cnt_final", 32'(cnt_q), 32'd3);

    // Pause/resume keeps the prescaler; out-of-range terminal never matches.
    load_val = 4'd0;
    term_val = 4'd15;
    press(3'b100);
    chk("t4_load_clears_wraps", 32'({state, wraps}), {25'd0, 3'd1, 4'd0});
    step_n(1);
    press(3'b001);
    chk("t4_run", 32'(state), 32'd2);
    step_n(4);
    chk("t4_first_step", 32'(cnt_step), 32'd1);
    stop_btn = 1'b1;
    step_n(3);
    chk("t4_pause", 32'(state), 32'd3);
    stop_btn = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cnt_step) nsteps++;
    end
    chk("t4_no_steps_paused", 32'(nsteps), 32'd0);
    chk("t4_pause_hold", 32'({state, cnt_q}), {25'd0, 3'd3, 4'd1});
    press(3'b001);
    chk("t4_resume", 32'(state), 32'd2);
    step_n(1);
    chk("t4_resume_no_step", 32'(cnt_step), 32'd0);
    step_n(1);
    chk("t4_resume_early_step", 32'(cnt_step), 32'd1);
    step_n(1);
    stop_btn = 1'b1;
    step_n(3);
    chk("t4_evt_beats_tick", 32'({state, cnt_step}), {28'd0, 3'd3, 1'b0});
    chk("t4_cnt", 32'(cnt_q), 32'd2);
    stop_btn = 1'b0;
    step_n(3);
    press(3'b010);
    chk("t4_stop_to_idle", 32'(state), 32'd0);

    // Coincident load and start in IDLE: load only.
    load_val = 4'd9;
    press(3'b101);
    chk("t5_load_wins", 32'({state, cnt_load, cnt_d}), {24'd0, 3'd1, 1'b1, 4'd9});
    step_n(1);
    chk("t5_idle", 32'(state), 32'd0);
    step_n(4);
    chk("t5_start_dropped", 32'({state, cnt_step}), 32'd0);

    // Asynchronous reset while a step strobe and a wrap are live.
    load_val = 4'd8;
    term_val = 4'd15;
    press(3'b100);
    step_n(1);
    chk("t6_cnt_loaded", 32'(cnt_q), 32'd8);
    press(3'b001);
    step_n(8);
    chk("t6_pre_rst", 32'({cnt_step, wraps, state}), {24'd0, 1'b1, 4'd1, 3'd2});
    #1 rst = 1'b1;
    #1;
    chk("t6_async_rst", 32'({cnt_step, wraps, state, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step_n(2);
    chk("t6_after_rst", 32'({state, cnt_step, cnt_load}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
